// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// One operand register, one register per prefix level, one result register.
module ks_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);

    // Prefix vectors are offset by one: position 0 carries c_in, position i holds bit i-1.
    logic             r_v    [0:LEVELS];
    logic [WIDTH-1:0] r_g    [0:LEVELS];
    logic [WIDTH-1:0] r_p    [0:LEVELS-1];
    logic [WIDTH-1:0] r_praw [0:LEVELS];
    logic             r_sa   [0:LEVELS];
    logic             r_sb   [0:LEVELS];

    logic             w_adv;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_bx     = sub ? ~b : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v[0]    <= 1'b0;
            r_g[0]    <= '0;
            r_p[0]    <= '0;
            r_praw[0] <= '0;
            r_sa[0]   <= 1'b0;
            r_sb[0]   <= 1'b0;
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            if (in_valid) begin
                r_g[0]    <= {a[WIDTH-2:0] & w_bx[WIDTH-2:0], sub | cin};
                r_p[0]    <= {a[WIDTH-2:0] ^ w_bx[WIDTH-2:0], 1'b0};
                r_praw[0] <= a ^ w_bx;
                r_sa[0]   <= a[WIDTH-1];
                r_sb[0]   <= w_bx[WIDTH-1];
            end
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int SPAN = 2 ** (k - 1);
        logic [WIDTH-1:0] w_g;

        assign w_g[SPAN-1:0]     = r_g[k-1][SPAN-1:0];
        assign w_g[WIDTH-1:SPAN] = r_g[k-1][WIDTH-1:SPAN]
                                 | (r_p[k-1][WIDTH-1:SPAN] & r_g[k-1][WIDTH-1-SPAN:0]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v[k]    <= 1'b0;
                r_g[k]    <= '0;
                r_praw[k] <= '0;
                r_sa[k]   <= 1'b0;
                r_sb[k]   <= 1'b0;
            end else if (w_adv) begin
                r_v[k]    <= r_v[k-1];
                r_g[k]    <= w_g;
                r_praw[k] <= r_praw[k-1];
                r_sa[k]   <= r_sa[k-1];
                r_sb[k]   <= r_sb[k-1];
            end
        end

        // The last level's propagate terms feed nothing, so they are not kept.
        if (k < LEVELS) begin : g_prop
            logic [WIDTH-1:0] w_p;

            assign w_p[SPAN-1:0]     = r_p[k-1][SPAN-1:0];
            assign w_p[WIDTH-1:SPAN] = r_p[k-1][WIDTH-1:SPAN] & r_p[k-1][WIDTH-1-SPAN:0];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_p[k] <= '0;
                end else if (w_adv) begin
                    r_p[k] <= w_p;
                end
            end
        end
    end

    // Top bit's g/p are rebuilt from the sign bits to close the carry-out.
    assign w_sum  = r_praw[LEVELS] ^ r_g[LEVELS];
    assign w_cout = (r_sa[LEVELS] & r_sb[LEVELS])
                  | (r_praw[LEVELS][WIDTH-1] & r_g[LEVELS][WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_v[LEVELS];
            if (r_v[LEVELS]) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= (r_sa[LEVELS] == r_sb[LEVELS]) && (w_sum[WIDTH-1] != r_sa[LEVELS]);
                r_zero <= (w_sum == '0);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe at WIDTH 8, 16 and 64: directed vectors,
// a random stream, a mid-stream stall and an asynchronous reset with work in flight.
module tb_ks_adder_pipe;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int unsigned t;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b1;
    logic [63:0] a_d = '0;
    logic [63:0] b_d = '0;
    logic        cin_d = 1'b0;
    logic        sub_d = 1'b0;
    logic        v8 = 1'b0, v16 = 1'b0, v64 = 1'b0;

    logic        rdy8, rdy16, rdy64;
    logic        ov8, ov16, ov64;
    logic        co8, co16, co64;
    logic        of8, of16, of64;
    logic        z8, z16, z64;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [63:0] s64;

    int unsigned cycle = 0;
    int          checks = 0;
    int          errors = 0;
    bit          lat_mode = 1'b0;
    exp_t        q8[$], q16[$], q64[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    ks_adder_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
        .a(a_d[7:0]), .b(b_d[7:0]), .cin(cin_d), .sub(sub_d),
        .out_valid(ov8), .out_ready(out_ready),
        .sum(s8), .cout(co8), .ovf(of8), .zero(z8));

    ks_adder_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
        .a(a_d[15:0]), .b(b_d[15:0]), .cin(cin_d), .sub(sub_d),
        .out_valid(ov16), .out_ready(out_ready),
        .sum(s16), .cout(co16), .ovf(of16), .zero(z16));

    ks_adder_pipe #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64),
        .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
        .out_valid(ov64), .out_ready(out_ready),
        .sum(s64), .cout(co64), .ovf(of64), .zero(z64));

    function automatic exp_t mk(logic [63:0] s, logic c, logic o, logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.t = 0; e.lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic c, logic s);
        logic [64:0] mask, bx, t;
        logic sa, sb;
        exp_t e;
        mask   = (65'd1 << w) - 65'd1;
        bx     = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        t      = ({1'b0, a} & mask) + bx + {64'd0, s | c};
        e      = mk(t[63:0] & mask[63:0], t[w], 1'b0, 1'b0);
        sa     = a[w-1];
        sb     = bx[w-1];
        e.ovf  = (sa == sb) && (e.sum[w-1] != sa);
        e.zero = (e.sum == 64'd0);
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check_res(string nm, exp_t e, logic [63:0] s, logic c, logic o, logic z, int lat);
        checks++;
        if (s !== e.sum || c !== e.cout || o !== e.ovf || z !== e.zero) begin
            errors++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                     nm, s, c, o, z, e.sum, e.cout, e.ovf, e.zero);
        end
        if (lat != 0 && e.lat) begin
            checks++;
            if (cycle - e.t != lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", nm, cycle - e.t, lat);
            end
        end
    endtask

    task automatic unexpected(string nm);
        checks++;
        errors++;
        $display("FAIL %s: output with empty scoreboard", nm);
    endtask

    // Monitors: a transfer pops the head; a stalled result is held against the head.
    always @(negedge clk) if (!rst && ov8) begin
        if (q8.size() == 0) unexpected("dut8");
        else if (out_ready) check_res("dut8", q8.pop_front(), {56'd0, s8}, co8, of8, z8, 5);
        else check_res("dut8 held", q8[0], {56'd0, s8}, co8, of8, z8, 0);
    end

    always @(negedge clk) if (!rst && ov16) begin
        if (q16.size() == 0) unexpected("dut16");
        else if (out_ready) check_res("dut16", q16.pop_front(), {48'd0, s16}, co16, of16, z16, 6);
        else check_res("dut16 held", q16[0], {48'd0, s16}, co16, of16, z16, 0);
    end

    always @(negedge clk) if (!rst && ov64) begin
        if (q64.size() == 0) unexpected("dut64");
        else if (out_ready) check_res("dut64", q64.pop_front(), s64, co64, of64, z64, 8);
        else check_res("dut64 held", q64[0], s64, co64, of64, z64, 0);
    end

    function automatic logic rdy_of(int w);
        return (w == 8) ? rdy8 : (w == 16) ? rdy16 : rdy64;
    endfunction

    task automatic send(int w, logic [63:0] a, logic [63:0] b, logic c, logic s, exp_t e);
        int g = 0;
        @(negedge clk);
        a_d = a; b_d = b; cin_d = c; sub_d = s;
        if (w == 8) v8 = 1'b1;
        else if (w == 16) v16 = 1'b1;
        else v64 = 1'b1;
        while (!rdy_of(w) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL send w%0d: in_ready stuck at 0", w);
        end
        e.t = cycle;
        e.lat = lat_mode;
        if (w == 8) q8.push_back(e);
        else if (w == 16) q16.push_back(e);
        else q64.push_back(e);
        @(posedge clk);
        #1;
        v8 = 1'b0; v16 = 1'b0; v64 = 1'b0;
    endtask

    task automatic send16_rand();
        logic [63:0] ra, rb;
        logic rc, rs;
        ra = {48'd0, 16'($urandom_range(0, 65535))};
        rb = {48'd0, 16'($urandom_range(0, 65535))};
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        send(16, ra, rb, rc, rs, model(16, ra, rb, rc, rs));
    endtask

    task automatic drain();
        int g = 0;
        while ((q8.size() + q16.size() + q64.size()) != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain pending", 64'(q8.size() + q16.size() + q64.size()), 64'd0);
    endtask

    initial begin
        #2;
        chk("reset out_valid", {61'd0, ov8, ov16, ov64}, 64'd0);
        chk("reset in_ready", {61'd0, rdy8, rdy16, rdy64}, 64'd7);
        chk("reset flags16", {61'd0, co16, of16, z16}, 64'd0);
        chk("reset sum16", {48'd0, s16}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        chk("in_ready after reset", {63'd0, rdy16}, 64'd1);

        lat_mode = 1'b1;
        send(8,  64'hFF, 64'h01, 1'b0, 1'b0, mk(64'h00, 1'b1, 1'b0, 1'b1));
        send(8,  64'h7F, 64'h01, 1'b0, 1'b0, mk(64'h80, 1'b0, 1'b1, 1'b0));
        send(8,  64'h05, 64'h07, 1'b0, 1'b1, mk(64'hFE, 1'b0, 1'b0, 1'b0));
        send(8,  64'h80, 64'h80, 1'b0, 1'b0, mk(64'h00, 1'b1, 1'b1, 1'b1));
        send(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, mk(64'h0, 1'b1, 1'b0, 1'b1));
        send(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0));
        send(64, 64'h0, 64'h1, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0));
        send(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0, mk(64'h0000, 1'b1, 1'b0, 1'b1));
        send(16, 64'h7FFF, 64'h0000, 1'b1, 1'b0, mk(64'h8000, 1'b0, 1'b1, 1'b0));
        send(16, 64'h8000, 64'h0001, 1'b0, 1'b1, mk(64'h7FFF, 1'b1, 1'b1, 1'b0));
        send(16, 64'h0003, 64'h0005, 1'b0, 1'b1, mk(64'hFFFE, 1'b0, 1'b0, 1'b0));
        send(16, 64'h1234, 64'h4321, 1'b1, 1'b0, mk(64'h5556, 1'b0, 1'b0, 1'b0));
        send(16, 64'h0005, 64'h0005, 1'b1, 1'b1, mk(64'h0000, 1'b1, 1'b0, 1'b1));
        repeat (100) send16_rand();
        drain();

        lat_mode = 1'b0;
        fork
            begin
                repeat (20) send16_rand();
            end
            begin
                repeat (8) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (6) @(negedge clk);
                chk("stall out_valid", {63'd0, ov16}, 64'd1);
                chk("stall in_ready", {63'd0, rdy16}, 64'd0);
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        @(posedge clk);
        #2 out_ready = 1'b0;
        send(16, 64'h8000, 64'h8001, 1'b0, 1'b0, mk(64'h0001, 1'b1, 1'b1, 1'b0));
        repeat (4) send16_rand();
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async reset out_valid", {63'd0, ov16}, 64'd0);
        chk("async reset sum", {48'd0, s16}, 64'd0);
        chk("async reset flags", {61'd0, co16, of16, z16}, 64'd0);
        chk("async reset in_ready", {63'd0, rdy16}, 64'd1);
        q16.delete();
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("no stale result", {63'd0, ov16}, 64'd0);
        lat_mode = 1'b1;
        send(16, 64'h00A5, 64'h005A, 1'b0, 1'b0, mk(64'h00FF, 1'b0, 1'b0, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ks_adder_pipe.md
KS_ADDER_PIPE -- requirements
Module: ks_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal values 4..64, powers of two only.
REQ-002 Parameter LEVELS, derived as clog2(WIDTH), number of Kogge-Stone prefix levels; not overridable.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operand set presented this cycle.
REQ-006 in_ready  out  1  block accepts the operand set this cycle.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 cin  in  1  carry-in; ignored when sub=1.
REQ-010 sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  out  1  result presented.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 sum  out  WIDTH  result bits [WIDTH-1:0].
REQ-014 cout  out  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-015 ovf  out  1  signed two's-complement overflow.
REQ-016 zero  out  1  sum == 0.

Function
REQ-017 Stage 0 register SHALL capture per-bit g = a&b', p = a^b' (b' = sub ? ~b : b) and effective carry-in c_in = sub | cin, plus sign bits of a and b'.
REQ-018 Stages 1..LEVELS SHALL each register one Kogge-Stone prefix level with span 2^(k-1): G = Gi | Pi&Gprev, P = Pi&Pprev; bits with no predecessor pass through; c_in folded in as generate of bit position -1.
REQ-019 Final stage SHALL register sum[i] = p[i] ^ c[i-1] (c[-1] = c_in), cout, ovf, zero.
REQ-020 Latency SHALL be exactly LEVELS+2 cycles from an accepting edge to out_valid with that result, absent stalls (WIDTH=16: 6 cycles).
REQ-021 Each stage SHALL carry a valid bit; throughput one operation per cycle when out_ready=1.
REQ-022 Pipeline advance condition adv = !out_valid | out_ready; in_ready SHALL equal adv combinationally.
REQ-023 When adv=0 every stage register and valid bit SHALL hold; sum/cout/ovf/zero SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Transfer in SHALL occur only on in_valid & in_ready; transfer out only on out_valid & out_ready.
REQ-025 Bubbles (stage valid=0) SHALL propagate; data in invalid stages is don't-care but outputs SHALL NOT change while out_valid=0 other than on a loading edge.
REQ-026 ovf SHALL equal (sign_a == sign_b') & (sum[WIDTH-1] != sign_a).
REQ-027 All arithmetic modulo 2^WIDTH; no saturation.
REQ-028 Results SHALL leave in acceptance order; no reordering, no drops, no duplicates.
REQ-029 Simultaneous out accept and in accept in the same cycle SHALL be supported with no lost slot.

Reset
REQ-030 On rst=1 all stage valid bits, out_valid, sum, cout, ovf, zero SHALL clear to 0 immediately, independent of clk.
REQ-031 in_ready SHALL read 1 during and after reset (follows REQ-022).
REQ-032 Operations in flight when rst asserts SHALL be discarded; none SHALL emerge after release.
REQ-033 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 WIDTH=8, a=0xFF b=0x01 cin=0 sub=0, out_ready=1 -> after 5 cycles sum=0x00 cout=1 ovf=0 zero=1.
REQ-035 WIDTH=8, a=0x7F b=0x01 sub=0 -> sum=0x80 cout=0 ovf=1; a=0x05 b=0x07 sub=1 -> sum=0xFE cout=0 ovf=0.
REQ-036 WIDTH=16, back-to-back stream of 100 random ops, out_ready=1 -> one result per cycle, 6-cycle latency, all match reference model (cin included).
REQ-037 WIDTH=16, out_ready held 0 for 10 cycles mid-stream -> in_ready=0 once out_valid=1, outputs stable, no loss/duplication after release.
REQ-038 rst pulsed mid-clock with 4 ops in flight -> outputs clear immediately, no stale result after release, next op exits with correct latency.
REQ-039 WIDTH=64 sweep: a=all-ones, b=0, cin=1 -> sum=0 cout=1 zero=1 (full-length carry chain).
